// File: rtl/tristate_delay_pkg.sv
// Shared types and defaults for the tri-state delay driver.
//   out_state_e : what the pad is doing (high-Z, driving 0, driving 1)
//   fsm_state_e : delay engine state (no pending change / change pending)
//   delay_of()  : maps a target pad state to its delay in clock cycles
package tristate_delay_pkg;

  typedef enum logic [1:0] {
    OUT_Z = 2'd0,
    OUT_0 = 2'd1,
    OUT_1 = 2'd2
  } out_state_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } fsm_state_e;

  localparam int unsigned DEF_RISE_DLY = 4;
  localparam int unsigned DEF_FALL_DLY = 6;
  localparam int unsigned DEF_OFF_DLY  = 8;
  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_STAT_W   = 8;

  // Delay needed to reach state s. Reaching 1 is a rise, reaching 0 a fall,
  // and reaching Z a turn-off, regardless of the state we come from.
  function automatic int unsigned delay_of(
    input out_state_e  s,
    input int unsigned rise = DEF_RISE_DLY,
    input int unsigned fall = DEF_FALL_DLY,
    input int unsigned off  = DEF_OFF_DLY
  );
    case (s)
      OUT_1:   return rise;
      OUT_0:   return fall;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/tristate_delay_driver_stat.sv
// Event counter used for the driver statistics.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   inc_i      : count one event this cycle
//   cnt_o      : current count; wraps when SATURATE=0, holds at all-ones
//                when SATURATE=1
module stat_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             hold;

  assign hold = SATURATE && (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !hold) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tristate_delay_driver.sv
// Clocked inverting tri-state pad driver with separate rise / fall /
// turn-off delays and inertial glitch rejection.
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : data in; the driven level is ~din
//   ctrl_n      : active-low enable (0 = drive, 1 = Z)
//   pad_out     : driven level, 0 whenever pad_oe=0
//   pad_oe      : pad output enable (0 = Z)
//   busy        : a transition is pending
//   trans_cnt   : applied output transitions (wraps)
//   glitch_cnt  : cancelled or replaced pending transitions (saturates)
//   dbg_state   : delay engine state (0 = idle, 1 = pending)
//
// Handshake: there is none; din/ctrl_n are sampled on every rising edge and
// the outputs are plain registered levels.
module tristate_delay_driver
  import tristate_delay_pkg::*;
#(
  parameter int unsigned RISE_DLY = DEF_RISE_DLY,
  parameter int unsigned FALL_DLY = DEF_FALL_DLY,
  parameter int unsigned OFF_DLY  = DEF_OFF_DLY,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              ctrl_n,
  output logic              pad_out,
  output logic              pad_oe,
  output logic              busy,
  output logic [STAT_W-1:0] trans_cnt,
  output logic [STAT_W-1:0] glitch_cnt,
  output logic              dbg_state
);

  localparam int unsigned MAX_DLY = (1 << CNT_W) - 1;

  // A delay of 0 would need an apply on the sampling edge itself, and a
  // delay above MAX_DLY does not fit the counter.
  if (RISE_DLY < 1 || RISE_DLY > MAX_DLY) begin : g_bad_rise
    $error("RISE_DLY out of range 1..2^CNT_W-1");
  end
  if (FALL_DLY < 1 || FALL_DLY > MAX_DLY) begin : g_bad_fall
    $error("FALL_DLY out of range 1..2^CNT_W-1");
  end
  if (OFF_DLY < 1 || OFF_DLY > MAX_DLY) begin : g_bad_off
    $error("OFF_DLY out of range 1..2^CNT_W-1");
  end

  function automatic logic [CNT_W-1:0] dly_cnt(input out_state_e s);
    return CNT_W'(delay_of(s, RISE_DLY, FALL_DLY, OFF_DLY));
  endfunction

  out_state_e       target;
  out_state_e       cur_q,   cur_d;
  out_state_e       pend_q,  pend_d;
  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pad_oe_q, pad_out_q, busy_q;
  logic             trans_inc, glitch_inc;

  // Inverting driver: din=0 drives 1, din=1 drives 0.
  always_comb begin
    if (ctrl_n) begin
      target = OUT_Z;
    end else if (din) begin
      target = OUT_0;
    end else begin
      target = OUT_1;
    end
  end

  // Next-state rules. In PEND, a target that moves away from the pending
  // value is checked before the apply, so a change on the apply edge always
  // cancels or replaces instead of applying.
  always_comb begin
    cur_d      = cur_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    trans_inc  = 1'b0;
    glitch_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (target != cur_q) begin
          pend_d  = target;
          cnt_d   = dly_cnt(target);
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (target == cur_q) begin
          // Input went back before the delay ran out: inertial rejection.
          state_d    = ST_IDLE;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (target != pend_q) begin
          // New destination: restart from its full delay.
          pend_d     = target;
          cnt_d      = dly_cnt(target);
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_W'(1)) begin
          cur_d     = pend_q;
          state_d   = ST_IDLE;
          cnt_d     = '0;
          trans_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next value of cur so they change on the
  // same edge as cur itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= OUT_Z;
      pend_q    <= OUT_Z;
      cnt_q     <= '0;
      pad_oe_q  <= 1'b0;
      pad_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      pad_oe_q  <= (cur_d != OUT_Z);
      pad_out_q <= (cur_d == OUT_1);
      busy_q    <= (state_d == ST_PEND);
    end
  end

  stat_counter #(
    .WIDTH   (STAT_W),
    .SATURATE(1'b0)
  ) u_trans_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(trans_inc),
    .cnt_o(trans_cnt)
  );

  stat_counter #(
    .WIDTH   (STAT_W),
    .SATURATE(1'b1)
  ) u_glitch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(glitch_inc),
    .cnt_o(glitch_cnt)
  );

  assign pad_oe    = pad_oe_q;
  assign pad_out   = pad_out_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tristate_delay_driver.sv
// Bench for tristate_delay_driver with default parameters
// (rise 4, fall 6, off 8 cycles, 8-bit statistics).
module tb_tristate_delay_driver;

  localparam int W = 19;  // {pad_oe, pad_out, busy, trans_cnt, glitch_cnt}

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       ctrl_n;
  logic       pad_out;
  logic       pad_oe;
  logic       busy;
  logic [7:0] trans_cnt;
  logic [7:0] glitch_cnt;
  logic       dbg_state;

  int errors;
  int checks;

  tristate_delay_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .ctrl_n    (ctrl_n),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .busy      (busy),
    .trans_cnt (trans_cnt),
    .glitch_cnt(glitch_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pad state as an int: 0 = driving 0, 1 = driving 1, 2 = Z.
  // Rule: the pad moves to a new target once that target has been sampled
  // on D+1 consecutive edges. Any change of target while a move is
  // outstanding counts as a glitch.
  int m_cur;
  int m_prev;   // target sampled on the previous edge
  int m_run;    // consecutive edges that sampled m_prev
  int m_trans;
  int m_glitch;

  function automatic int tgt_of(input logic d, input logic c);
    if (c) return 2;
    return d ? 0 : 1;
  endfunction

  function automatic int dly_of(input int t);
    if (t == 1) return 4;
    if (t == 0) return 6;
    return 8;
  endfunction

  task automatic model_reset();
    m_cur    = 2;
    m_prev   = 2;
    m_run    = 0;
    m_trans  = 0;
    m_glitch = 0;
  endtask

  task automatic model_edge(input logic d, input logic c);
    int t;
    t = tgt_of(d, c);
    if ((m_prev != m_cur) && (t != m_prev) && (m_glitch < 255)) m_glitch++;
    if (t == m_prev) m_run++;
    else m_run = 1;
    m_prev = t;
    if ((t != m_cur) && (m_run == dly_of(t) + 1)) begin
      m_cur = t;
      m_trans++;
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [7:0] tr;
    logic [7:0] gl;
    tr = 8'(m_trans);
    gl = 8'(m_glitch);
    return {(m_cur != 2), (m_cur == 1), (m_prev != m_cur), tr, gl};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {pad_oe, pad_out, busy, trans_cnt, glitch_cnt};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got oe=%0b out=%0b busy=%0b trans=%0d glitch=%0d, expected oe=%0b out=%0b busy=%0b trans=%0d glitch=%0d",
               name, act[18], act[17], act[16], act[15:8], act[7:0],
               exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs, take one rising edge, advance the model, sample #1 later.
  task automatic step(input logic d, input logic c);
    din    = d;
    ctrl_n = c;
    @(posedge clk);
    model_edge(d, c);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic d;
    logic c;
    int   n;     // edges to hold these inputs
    logic oe;
    logic out;
    logic bsy;
    int   tr;
    int   gl;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [W-1:0] pack_exp(input logic oe, input logic out,
                                            input logic bsy, input int tr,
                                            input int gl);
    logic [7:0] t8;
    logic [7:0] g8;
    t8 = 8'(tr);
    g8 = 8'(gl);
    return {oe, out, bsy, t8, g8};
  endfunction

  initial begin
    errors = 0;
    checks = 0;

    //          d  c  n  oe out bsy tr gl
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 0};  // din toggles under Z: no event
    vecs[1]  = '{0, 1, 2, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 4, 0, 0, 1, 0, 0};  // rise pending
    vecs[3]  = '{0, 0, 1, 1, 1, 0, 1, 0};  // drives 1 after 4 cycles
    vecs[4]  = '{1, 0, 6, 1, 1, 1, 1, 0};
    vecs[5]  = '{1, 0, 1, 1, 0, 0, 2, 0};  // fall after 6
    vecs[6]  = '{1, 1, 8, 1, 0, 1, 2, 0};
    vecs[7]  = '{1, 1, 1, 0, 0, 0, 3, 0};  // Z after 8
    vecs[8]  = '{1, 0, 7, 1, 0, 0, 4, 0};  // Z -> 0
    vecs[9]  = '{0, 0, 3, 1, 0, 1, 4, 0};  // short low pulse on din
    vecs[10] = '{1, 0, 1, 1, 0, 0, 4, 1};  // cancelled
    vecs[11] = '{1, 0, 2, 1, 0, 0, 4, 1};
    vecs[12] = '{0, 0, 5, 1, 1, 0, 5, 1};  // back to driven 1
    vecs[13] = '{1, 0, 3, 1, 1, 1, 5, 1};  // fall pending
    vecs[14] = '{1, 1, 1, 1, 1, 1, 5, 2};  // replaced by turn-off
    vecs[15] = '{1, 1, 7, 1, 1, 1, 5, 2};
    vecs[16] = '{1, 1, 1, 0, 0, 0, 6, 2};  // Z with no 0 in between
    vecs[17] = '{0, 0, 4, 0, 0, 1, 6, 2};  // rise pending, cnt reaches 1
    vecs[18] = '{1, 0, 1, 0, 0, 1, 6, 3};  // change on apply edge: replace
    vecs[19] = '{1, 0, 6, 1, 0, 0, 7, 3};  // fall applied after full delay

    // Reset
    rst_n  = 1'b0;
    din    = 1'b0;
    ctrl_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", dut_vec(), pack_exp(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < vecs[i].n; k++) step(vecs[i].d, vecs[i].c);
      check($sformatf("vec%0d", i), dut_vec(),
            pack_exp(vecs[i].oe, vecs[i].out, vecs[i].bsy, vecs[i].tr, vecs[i].gl));
    end

    // Async reset in the middle of a pending rise (cnt=3), between edges
    step(0, 0);
    step(0, 0);
    check("pre_reset_busy", dut_vec(), pack_exp(1, 0, 1, 7, 3));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), pack_exp(0, 0, 0, 0, 0));
    model_reset();
    @(posedge clk);
    #1;
    check("reset_hold", dut_vec(), pack_exp(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(0, 0);
    check("fresh_delay_pending", dut_vec(), pack_exp(0, 0, 1, 0, 0));
    step(0, 0);
    check("fresh_delay_done", dut_vec(), pack_exp(1, 1, 0, 1, 0));

    // Randomised segments against the model
    for (int s = 0; s < 150; s++) begin
      logic rd;
      logic rc;
      int   hold;
      rd   = 1'($urandom_range(0, 1));
      rc   = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) step(rd, rc);
    end

    // Glitch counter saturation: one cancel per two edges
    for (int k = 0; k < 9; k++) step(1, 0);
    for (int g = 0; g < 300; g++) begin
      step(0, 0);
      step(1, 0);
    end
    check("glitch_saturated", {3'b000, 8'h00, glitch_cnt}, {3'b000, 8'h00, 8'hff});

    // Transition counter wrap
    for (int t = 0; t < 260; t++) begin
      if (t % 2 == 0) begin
        for (int k = 0; k < 5; k++) step(0, 0);
      end else begin
        for (int k = 0; k < 7; k++) step(1, 0);
      end
    end
    check("trans_wrap", {11'h000, trans_cnt}, {11'h000, 8'(m_trans % 256)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
